// File: rtl/regfile_operand_fetch_pkg.sv
// Shared core definitions: register-index width derivation and default operand-bundle widths,
// used by the register file, operand fetch and execute stage.
package regfile_operand_fetch_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_NUM_REGISTERS = 4;

    // Index width for a register count; callers guarantee a power of two >= 2.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bit per register: set on accepted write-enabled issue, cleared by writeback (set wins).
// Three combinational lookups; no backpressure of its own.
module regfile_scoreboard
    import regfile_operand_fetch_pkg::*;
#(
    parameter int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
    localparam int ADDR_WIDTH   = clog2(NUM_REGISTERS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] look_a,
    input  logic [ADDR_WIDTH-1:0] look_b,
    input  logic [ADDR_WIDTH-1:0] look_d,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  busy_d
);

    logic [NUM_REGISTERS-1:0] busy;

    // The set is applied after the clear so a same-index collision leaves the bit set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            if (clr_en) begin
                busy[clr_addr] <= 1'b0;
            end
            if (set_en) begin
                busy[set_addr] <= 1'b1;
            end
        end
    end

    assign busy_a = busy[look_a];
    assign busy_b = busy[look_b];
    assign busy_d = busy[look_d];

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch: scoreboard hazard stall, writeback bypass, registered bundle to execute.
// Latency 1 issue->op_valid; holds the bundle while op_ready is low and stalls issue meanwhile.
module regfile_operand_fetch
    import regfile_operand_fetch_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
    localparam int ADDR_WIDTH   = clog2(NUM_REGISTERS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] issue_src_a,
    input  logic [ADDR_WIDTH-1:0] issue_src_b,
    input  logic [ADDR_WIDTH-1:0] issue_dest,
    input  logic                  issue_dest_en,
    output logic [ADDR_WIDTH-1:0] rf_addr_a,
    output logic [ADDR_WIDTH-1:0] rf_addr_b,
    input  logic [DATA_WIDTH-1:0] rf_data_a,
    input  logic [DATA_WIDTH-1:0] rf_data_b,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic [ADDR_WIDTH-1:0] op_dest,
    output logic                  op_dest_en
);

    logic busy_a, busy_b, busy_d;
    logic wb_hit_a, wb_hit_b, wb_hit_d;
    logic hz_a, hz_b, hz_d;
    logic free, accept;

    assign rf_addr_a = issue_src_a;
    assign rf_addr_b = issue_src_b;

    // A writeback landing this cycle resolves the hazard on its register and supplies the data.
    assign wb_hit_a = wb_valid && (wb_addr == issue_src_a);
    assign wb_hit_b = wb_valid && (wb_addr == issue_src_b);
    assign wb_hit_d = wb_valid && (wb_addr == issue_dest);

    assign hz_a = busy_a && !wb_hit_a;
    assign hz_b = busy_b && !wb_hit_b;
    assign hz_d = issue_dest_en && busy_d && !wb_hit_d;

    assign free        = !op_valid || op_ready;
    assign issue_ready = free && !hz_a && !hz_b && !hz_d;
    assign accept      = issue_valid && issue_ready;

    regfile_scoreboard #(
        .NUM_REGISTERS (NUM_REGISTERS)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (accept && issue_dest_en),
        .set_addr (issue_dest),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .look_a   (issue_src_a),
        .look_b   (issue_src_b),
        .look_d   (issue_dest),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .busy_d   (busy_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_valid   <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_dest    <= '0;
            op_dest_en <= 1'b0;
        end else if (accept) begin
            op_valid   <= 1'b1;
            op_a       <= wb_hit_a ? wb_data : rf_data_a;
            op_b       <= wb_hit_b ? wb_data : rf_data_b;
            op_dest    <= issue_dest;
            op_dest_en <= issue_dest_en;
        end else if (op_ready) begin
            op_valid   <= 1'b0;
        end
    end

endmodule
